div_ctrl: RTL and testbench

Sequencing controller between the EX stage and the two AXI-stream divider cores: the signed core (div_gen_0) and the unsigned core (div_gen_1).
- Accepts one divide request at a time and issues it to the core selected by op.
- Waits for that core's result, selects quotient or remainder, and holds the response until the consumer accepts it.
- Handles pipeline flush by draining and discarding the in-flight result.
- Provides busy for EX stall generation and a last-operation latency counter for performance monitoring.

---
 rtl/div_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_div_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller between the EX stage and the two
// AXI-stream divider cores (div_gen_0 signed, div_gen_1 unsigned).
// One request at a time: latch, issue to the selected core, wait for the
// result, pick quotient or remainder, and hold it until it is accepted.
// A flush while the core owns the operation marks it killed. The core
// handshake and result still complete, and the result is dropped silently.

module div_ctrl #(
    parameter int LAT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,

    // EX-stage request
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_src1,
    input  logic [31:0]      req_src2,
    input  logic             flush,

    // signed core (div_gen_0)
    output logic             dvs_tvalid,
    input  logic             dvs_tready,
    output logic [31:0]      dvs_dividend,
    output logic [31:0]      dvs_divisor,
    input  logic             dvs_dout_tvalid,
    input  logic [63:0]      dvs_dout_tdata,

    // unsigned core (div_gen_1)
    output logic             dvu_tvalid,
    input  logic             dvu_tready,
    output logic [31:0]      dvu_dividend,
    output logic [31:0]      dvu_divisor,
    input  logic             dvu_dout_tvalid,
    input  logic [63:0]      dvu_dout_tdata,

    // response to the consumer
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,

    // status
    output logic             busy,
    output logic [LAT_W-1:0] last_lat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [1:0]       op_q,       op_d;
    logic [31:0]      src1_q,     src1_d;
    logic [31:0]      src2_q,     src2_d;
    logic [31:0]      result_q,   result_d;
    logic             killed_q,   killed_d;
    logic [LAT_W-1:0] lat_cnt_q,  lat_cnt_d;
    logic [LAT_W-1:0] last_lat_q, last_lat_d;

    // op[1] picks the core, op[0] picks remainder over quotient.
    logic             use_dvu;
    logic             take_rem;
    logic             sel_tready;
    logic             sel_dout_valid;
    logic [63:0]      sel_dout_data;
    logic [31:0]      sel_result;
    logic [LAT_W-1:0] lat_cnt_inc;

    assign use_dvu  = op_q[1];
    assign take_rem = op_q[0];

    // Only the core that owns the operation is listened to; the other core's
    // handshake and result strobes are ignored in every state.
    assign sel_tready     = use_dvu ? dvu_tready      : dvs_tready;
    assign sel_dout_valid = use_dvu ? dvu_dout_tvalid : dvs_dout_tvalid;
    assign sel_dout_data  = use_dvu ? dvu_dout_tdata  : dvs_dout_tdata;

    // Core result layout: [63:32] quotient, [31:0] remainder.
    assign sel_result = take_rem ? sel_dout_data[31:0] : sel_dout_data[63:32];

    // Latency counter saturates at all-ones instead of wrapping.
    assign lat_cnt_inc = (lat_cnt_q == {LAT_W{1'b1}}) ? lat_cnt_q
                                                      : lat_cnt_q + LAT_W'(1);

    // Next-state and datapath-register update rules for the sequencer.
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        result_d   = result_q;
        killed_d   = killed_q;
        lat_cnt_d  = lat_cnt_q;
        last_lat_d = last_lat_q;

        case (state_q)
            IDLE: begin
                // A request that coincides with flush is dropped outright.
                if (req_valid && !flush) begin
                    op_d    = req_op;
                    src1_d  = req_src1;
                    src2_d  = req_src2;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                // tvalid is never withdrawn: a flush here only marks the
                // operation so its result is swallowed later.
                if (flush) begin
                    killed_d = 1'b1;
                end
                if (sel_tready) begin
                    lat_cnt_d = LAT_W'(1);
                    state_d   = WAIT;
                end
            end

            WAIT: begin
                lat_cnt_d = lat_cnt_inc;
                if (sel_dout_valid) begin
                    if (killed_q || flush) begin
                        killed_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        result_d   = sel_result;
                        last_lat_d = lat_cnt_q;
                        state_d    = DONE;
                    end
                end else if (flush) begin
                    killed_d = 1'b1;
                end
            end

            DONE: begin
                // Accept and flush both retire the response; flush alone
                // drops it, flush with accept counts as delivered.
                if (rsp_ready || flush) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by resetn.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            src1_q     <= 32'h0;
            src2_q     <= 32'h0;
            result_q   <= 32'h0;
            killed_q   <= 1'b0;
            lat_cnt_q  <= '0;
            last_lat_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            result_q   <= result_d;
            killed_q   <= killed_d;
            lat_cnt_q  <= lat_cnt_d;
            last_lat_q <= last_lat_d;
        end
    end

    // Outputs decode straight from registered state, so they take their
    // reset values the instant resetn falls.
    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);

    assign dvs_tvalid   = (state_q == ISSUE) && !use_dvu;
    assign dvu_tvalid   = (state_q == ISSUE) &&  use_dvu;

    // Both cores see the latched operands; only the selected tvalid is live.
    assign dvs_dividend = src1_q;
    assign dvs_divisor  = src2_q;
    assign dvu_dividend = src1_q;
    assign dvu_divisor  = src2_q;

    assign rsp_valid    = (state_q == DONE);
    assign rsp_result   = result_q;
    assign last_lat     = last_lat_q;

    // Interface contract checks, ignored by synthesis.
    a_one_core: assert property (@(posedge clk) disable iff (!resetn)
        !(dvs_tvalid && dvu_tvalid));

    a_dvs_hold: assert property (@(posedge clk) disable iff (!resetn)
        (dvs_tvalid && !dvs_tready) |=>
            (dvs_tvalid && $stable(dvs_dividend) && $stable(dvs_divisor)));

    a_dvu_hold: assert property (@(posedge clk) disable iff (!resetn)
        (dvu_tvalid && !dvu_tready) |=>
            (dvu_tvalid && $stable(dvu_dividend) && $stable(dvu_divisor)));

    a_rsp_hold: assert property (@(posedge clk) disable iff (!resetn)
        (rsp_valid && !rsp_ready && !flush) |=>
            (rsp_valid && $stable(rsp_result)));

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl. Two behavioural divider cores
// drive the result channels: each has a programmable tready stall and a
// programmable result latency. A transaction-level model predicts the
// response from plain arithmetic on the accepted request. A per-cycle
// compare process checks the core-side and response-side outputs against
// that model. Directed sequences pin timing and results with literals.

module tb_div_ctrl;

    localparam int LAT_W = 8;

    logic             clk;
    logic             resetn;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_src1;
    logic [31:0]      req_src2;
    logic             flush;
    logic             dvs_tvalid;
    logic             dvs_tready;
    logic [31:0]      dvs_dividend;
    logic [31:0]      dvs_divisor;
    logic             dvs_dout_tvalid;
    logic [63:0]      dvs_dout_tdata;
    logic             dvu_tvalid;
    logic             dvu_tready;
    logic [31:0]      dvu_dividend;
    logic [31:0]      dvu_divisor;
    logic             dvu_dout_tvalid;
    logic [63:0]      dvu_dout_tdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             busy;
    logic [LAT_W-1:0] last_lat;

    div_ctrl #(.LAT_W(LAT_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_src1        (req_src1),
        .req_src2        (req_src2),
        .flush           (flush),
        .dvs_tvalid      (dvs_tvalid),
        .dvs_tready      (dvs_tready),
        .dvs_dividend    (dvs_dividend),
        .dvs_divisor     (dvs_divisor),
        .dvs_dout_tvalid (dvs_dout_tvalid),
        .dvs_dout_tdata  (dvs_dout_tdata),
        .dvu_tvalid      (dvu_tvalid),
        .dvu_tready      (dvu_tready),
        .dvu_dividend    (dvu_dividend),
        .dvu_divisor     (dvu_divisor),
        .dvu_dout_tvalid (dvu_dout_tvalid),
        .dvu_dout_tdata  (dvu_dout_tdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .busy            (busy),
        .last_lat        (last_lat)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bookkeeping and checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Division model: {quotient, remainder}, truncating toward zero.
    function automatic logic [63:0] core_calc(input bit sgn, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Expected response for a request, straight from the op encoding.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] qr;
        qr = core_calc(!op[1], a, b);
        return op[0] ? qr[31:0] : qr[63:32];
    endfunction

    // Transaction model of the operation currently owned by the DUT
    logic [1:0]  exp_op     = 2'b00;
    logic [31:0] exp_src1   = 32'h0;
    logic [31:0] exp_src2   = 32'h0;
    logic [31:0] exp_result = 32'h0;
    bit          exp_live   = 1'b0;   // a response may legally appear
    int          acc_cyc    = 0;

    // Behavioural cores
    int          core_lat     = 8;
    int          stall_cycles = 0;
    int          hs_count     = 0;
    int          s_wait       = 0;
    int          u_wait       = 0;
    int          emu_cnt      = 0;
    bit          emu_sgn      = 1'b0;
    logic [31:0] emu_a        = 32'h0;
    logic [31:0] emu_b        = 32'h0;
    logic        emu_dvs_v    = 1'b0;
    logic        emu_dvu_v    = 1'b0;
    logic        inj_dvs_v    = 1'b0;

    assign dvs_dout_tvalid = emu_dvs_v | inj_dvs_v;
    assign dvu_dout_tvalid = emu_dvu_v;

    initial begin : core_emu
        bit hs_s;
        bit hs_u;
        bit tv_s;
        bit tv_u;
        dvs_tready     = 1'b1;
        dvu_tready     = 1'b1;
        dvs_dout_tdata = 64'h0;
        dvu_dout_tdata = 64'h0;
        forever begin
            @(negedge clk);
            tv_s = dvs_tvalid;
            tv_u = dvu_tvalid;
            hs_s = dvs_tvalid && dvs_tready;
            hs_u = dvu_tvalid && dvu_tready;
            if (hs_s) begin
                emu_a = dvs_dividend; emu_b = dvs_divisor; emu_sgn = 1'b1;
            end
            if (hs_u) begin
                emu_a = dvu_dividend; emu_b = dvu_divisor; emu_sgn = 1'b0;
            end
            @(posedge clk);
            #1;
            emu_dvs_v = 1'b0;
            emu_dvu_v = 1'b0;
            if (emu_cnt > 0) begin
                emu_cnt--;
                if (emu_cnt == 0) begin
                    if (emu_sgn) begin
                        emu_dvs_v      = 1'b1;
                        dvs_dout_tdata = core_calc(1'b1, emu_a, emu_b);
                    end else begin
                        emu_dvu_v      = 1'b1;
                        dvu_dout_tdata = core_calc(1'b0, emu_a, emu_b);
                    end
                end
            end
            if (hs_s || hs_u) begin
                emu_cnt = core_lat;
                hs_count++;
            end
            s_wait     = hs_s ? 0 : (tv_s ? s_wait + 1 : s_wait);
            u_wait     = hs_u ? 0 : (tv_u ? u_wait + 1 : u_wait);
            dvs_tready = (s_wait >= stall_cycles);
            dvu_tready = (u_wait >= stall_cycles);
        end
    end

    // Per-cycle compare against the transaction model
    int tvs_cycles = 0;
    int tvu_cycles = 0;

    always @(negedge clk) begin
        if (resetn) begin
            check("busy_vs_req_ready", busy, !req_ready);
            check("one_core_only", dvs_tvalid & dvu_tvalid, 1'b0);
            if (dvs_tvalid || dvu_tvalid)
                check("core_select", dvu_tvalid, exp_op[1]);
            if (dvs_tvalid) begin
                tvs_cycles++;
                check("dvs_dividend", dvs_dividend, exp_src1);
                check("dvs_divisor", dvs_divisor, exp_src2);
            end
            if (dvu_tvalid) begin
                tvu_cycles++;
                check("dvu_dividend", dvu_dividend, exp_src1);
                check("dvu_divisor", dvu_divisor, exp_src2);
            end
            if (rsp_valid) begin
                check("rsp_expected", exp_live, 1'b1);
                check("rsp_result_model", rsp_result, exp_result);
            end
        end
    end

    // Stimulus helpers (called at posedge+1)
    task automatic send_req(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        int n = 0;
        tvs_cycles = 0;
        tvu_cycles = 0;
        req_op = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_accept", req_ready, 1'b1);
        exp_op = op; exp_src1 = a; exp_src2 = b;
        exp_result = ref_result(op, a, b);
        exp_live = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_src1  = 32'hDEAD_BEEF;
        req_src2  = 32'h0BAD_F00D;
        req_op    = ~op;
        acc_cyc   = cyc;
    endtask

    task automatic wait_rsp(output int lat);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_seen", rsp_valid, 1'b1);
        lat = cyc - acc_cyc;
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_live  = 1'b0;
    endtask

    task automatic wait_dout();
        int n = 0;
        @(negedge clk);
        while (!(dvs_dout_tvalid || dvu_dout_tvalid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("core_dout_seen", dvs_dout_tvalid | dvu_dout_tvalid, 1'b1);
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat_core, input logic [31:0] res,
                         input int exp_lat, input int exp_last);
        int lat;
        core_lat = lat_core;
        send_req(op, a, b);
        wait_rsp(lat);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, rsp_result, res);
        check({name, "_last_lat"}, last_lat, exp_last);
        accept_rsp();
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int lat;
        int hs_before;
        req_valid = 1'b0; req_op = 2'b00; req_src1 = 32'h0; req_src2 = 32'h0;
        flush = 1'b0; rsp_ready = 1'b0;
        resetn = 1'b0;
        #2;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_tvalid", {dvs_tvalid, dvu_tvalid}, 2'b00);
        check("reset_last_lat", last_lat, 0);
        check("reset_rsp_result", rsp_result, 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // 1: div.w -7/2, core latency 8
        do_op("t1_divw", 2'b00, 32'hFFFF_FFF9, 32'd2, 8, 32'hFFFF_FFFD, 10, 9);
        check("t1_dvs_tvalid_cycles", tvs_cycles, 1);
        check("t1_dvu_tvalid_cycles", tvu_cycles, 0);

        // 2: remaining op codes
        do_op("t2_modw", 2'b01, 32'hFFFF_FFF9, 32'd2, 3, 32'hFFFF_FFFF, 5, 4);
        do_op("t2_divwu", 2'b10, 32'hFFFF_FFF9, 32'd2, 1, 32'h7FFF_FFFC, 3, 2);
        check("t2_divwu_dvs_cycles", tvs_cycles, 0);
        check("t2_divwu_dvu_cycles", tvu_cycles, 1);
        do_op("t2_modwu", 2'b11, 32'd100, 32'd7, 5, 32'h0000_0002, 7, 6);

        // 3: tready stalled 3 cycles, flush in the second ISSUE cycle
        stall_cycles = 3;
        core_lat     = 4;
        hs_before    = hs_count;
        send_req(2'b11, 32'h0000_1234, 32'h0000_0010);
        @(posedge clk); #1;
        flush = 1'b1;
        exp_live = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_dout();
        check("t3_dvu_tvalid_cycles", tvu_cycles, 4);
        check("t3_handshake_done", hs_count, hs_before + 1);
        check("t3_busy_at_dout", busy, 1'b1);
        @(negedge clk);
        check("t3_busy_after_dout", busy, 1'b0);
        check("t3_no_rsp", rsp_valid, 1'b0);
        check("t3_last_lat_kept", last_lat, 6);
        stall_cycles = 0;
        @(posedge clk); #1;
        do_op("t3_next", 2'b10, 32'd50, 32'd5, 2, 32'h0000_000A, 4, 3);

        // 4a: request together with flush in IDLE is ignored
        req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd3;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("t4_flush_req_busy", busy, 1'b0);
        check("t4_flush_req_ready", req_ready, 1'b1);

        // 4b: flush during WAIT, then spurious dout in IDLE
        @(posedge clk); #1;
        core_lat = 6;
        send_req(2'b00, 32'd1000, 32'd10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        exp_live = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_dout();
        @(negedge clk);
        check("t4_busy_after_dout", busy, 1'b0);
        check("t4_last_lat_kept", last_lat, 3);
        @(posedge clk); #1;
        inj_dvs_v = 1'b1;
        @(posedge clk); #1;
        inj_dvs_v = 1'b0;
        @(negedge clk);
        check("t4_spurious_busy", busy, 1'b0);
        check("t4_spurious_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1;
        do_op("t4_next", 2'b00, 32'd20, 32'd3, 4, 32'h0000_0006, 6, 5);

        // 5: consumer holds rsp_ready low 5 cycles, accepts on cycle 6
        core_lat = 2;
        send_req(2'b01, 32'hFFFF_FFEC, 32'd3);
        wait_rsp(lat);
        check("t5_latency", lat, 4);
        check("t5_last_lat", last_lat, 3);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_rsp_valid", rsp_valid, 1'b1);
            check("t5_hold_result", rsp_result, 32'hFFFF_FFFE);
            check("t5_hold_req_ready", req_ready, 1'b0);
            check("t5_hold_busy", busy, 1'b1);
            @(negedge clk);
        end
        accept_rsp();
        @(negedge clk);
        check("t5_req_ready_after", req_ready, 1'b1);
        check("t5_rsp_gone", rsp_valid, 1'b0);

        // 5b: flush in DONE without accept drops the response
        @(posedge clk); #1;
        core_lat = 1;
        send_req(2'b00, 32'hFFFF_FFEC, 32'd3);
        wait_rsp(lat);
        check("t5b_result", rsp_result, 32'hFFFF_FFFA);
        #1;
        flush = 1'b1;
        exp_live = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t5b_dropped", rsp_valid, 1'b0);
        check("t5b_idle", req_ready, 1'b1);

        // 6: reset in the middle of WAIT
        @(posedge clk); #1;
        core_lat = 10;
        send_req(2'b10, 32'h8000_0000, 32'd4);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("t6_busy_in_wait", busy, 1'b1);
        #2;
        resetn = 1'b0;
        exp_live = 1'b0;
        #1;
        check("t6_rst_req_ready", req_ready, 1'b1);
        check("t6_rst_rsp_valid", rsp_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_tvalid", {dvs_tvalid, dvu_tvalid}, 2'b00);
        check("t6_rst_last_lat", last_lat, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        wait_dout();
        @(negedge clk);
        check("t6_stale_busy", busy, 1'b0);
        check("t6_stale_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1;
        do_op("t6_next", 2'b01, 32'hFFFF_FFF9, 32'd2, 3, 32'hFFFF_FFFF, 5, 4);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
